// File: rtl/uart_lite_stream_bridge_pkg.sv
// UartLite register map, STAT bit positions and bridge FSM states shared by the
// stream bridge, its buffers and anything that talks to the same peripheral.
package uart_pkg;

    localparam logic [3:0] UARTLITE_RX_OFS   = 4'h0;
    localparam logic [3:0] UARTLITE_TX_OFS   = 4'h4;
    localparam logic [3:0] UARTLITE_STAT_OFS = 4'h8;
    localparam logic [3:0] UARTLITE_CTRL_OFS = 4'hC;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_FULL  = 3;

    localparam logic [2:0] AXI_PROT  = 3'b000;
    localparam logic [3:0] AXI_WSTRB = 4'b0001;

    typedef enum logic [2:0] {
        IDLE,
        AR_STAT,
        R_STAT,
        AR_RX,
        R_RX,
        WR,
        B
    } bridge_state_e;

    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [3:0] ofs);
        return base + {28'd0, ofs};
    endfunction

endpackage

// File: rtl/uart_lite_stream_bridge_if.sv
// AXI4-Lite link between the stream bridge (master) and the UartLite peripheral (slave).
interface uart_lite_stream_bridge_if;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arprot, input arready,
        input rvalid, rdata, rresp, output rready
    );

    modport slave (
        input awvalid, awaddr, awprot, output awready,
        input wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp, input rready
    );

endinterface

// File: rtl/uart_lite_stream_bridge_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output; push when full
// and pop when empty are ignored so callers may hold requests without gating.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_lite_stream_bridge.sv
// Byte-stream front end for a UartLite: polls STAT over AXI4-Lite and moves bytes
// between the peripheral FIFOs and local RX/TX buffers, alternating when both need service.
module uart_lite_stream_bridge
    import uart_pkg::*;
#(
    parameter int          RX_DEPTH  = 16,
    parameter int          TX_DEPTH  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DATA_W    = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic                        err,
    input  logic                        err_clr,
    uart_lite_stream_bridge_if.master   axi
);

    bridge_state_e     state;
    logic              rr_tx;
    logic              rx_push;
    logic              rx_empty;
    logic              rx_full;
    logic              tx_pop;
    logic              tx_empty;
    logic              tx_full;
    logic [DATA_W-1:0] tx_head;
    logic [31:0]       stat_word;
    logic              want_rx;
    logic              want_tx;
    logic              pick_rx;
    logic              unused_rdata;

    assign axi.awprot = AXI_PROT;
    assign axi.arprot = AXI_PROT;
    assign axi.wstrb  = AXI_WSTRB;

    assign rx_push  = (state == R_RX) && axi.rready && axi.rvalid;
    assign tx_pop   = (state == B) && axi.bready && axi.bvalid;
    assign rx_valid = !rx_empty;
    assign tx_ready = !tx_full;

    sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rx_push),
        .push_data (axi.rdata[DATA_W-1:0]),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .empty     (rx_empty),
        .full      (rx_full),
        .level     (rx_level)
    );

    sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .empty     (tx_empty),
        .full      (tx_full),
        .level     (tx_level)
    );

    // A failed STAT read reads as all-zero so nothing gets serviced this round.
    assign stat_word    = (axi.rresp == 2'b00) ? axi.rdata : 32'd0;
    assign want_rx      = stat_word[STAT_RX_VALID] && !rx_full;
    assign want_tx      = !tx_empty && !stat_word[STAT_TX_FULL];
    assign pick_rx      = want_rx && (!want_tx || !rr_tx);
    assign unused_rdata = ^axi.rdata;

    // err_clr is applied first so a same-cycle error response overrides it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            rr_tx       <= 1'b0;
            err         <= 1'b0;
            axi.arvalid <= 1'b0;
            axi.araddr  <= '0;
            axi.rready  <= 1'b0;
            axi.awvalid <= 1'b0;
            axi.awaddr  <= '0;
            axi.wvalid  <= 1'b0;
            axi.wdata   <= '0;
            axi.bready  <= 1'b0;
        end else begin
            if (err_clr) err <= 1'b0;
            unique case (state)
                IDLE: begin
                    axi.arvalid <= 1'b1;
                    axi.araddr  <= reg_addr(BASE_ADDR, UARTLITE_STAT_OFS);
                    state       <= AR_STAT;
                end
                AR_STAT: begin
                    if (axi.arready) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state       <= R_STAT;
                    end
                end
                R_STAT: begin
                    if (axi.rvalid) begin
                        axi.rready <= 1'b0;
                        if (axi.rresp != 2'b00) err <= 1'b1;
                        if (want_rx && want_tx) rr_tx <= !rr_tx;
                        if (pick_rx) begin
                            axi.arvalid <= 1'b1;
                            axi.araddr  <= reg_addr(BASE_ADDR, UARTLITE_RX_OFS);
                            state       <= AR_RX;
                        end else if (want_tx) begin
                            axi.awvalid <= 1'b1;
                            axi.wvalid  <= 1'b1;
                            axi.awaddr  <= reg_addr(BASE_ADDR, UARTLITE_TX_OFS);
                            axi.wdata   <= 32'(tx_head);
                            state       <= WR;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                AR_RX: begin
                    if (axi.arready) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state       <= R_RX;
                    end
                end
                R_RX: begin
                    if (axi.rvalid) begin
                        axi.rready <= 1'b0;
                        if (axi.rresp != 2'b00) err <= 1'b1;
                        state <= IDLE;
                    end
                end
                WR: begin
                    if (axi.awready) axi.awvalid <= 1'b0;
                    if (axi.wready)  axi.wvalid  <= 1'b0;
                    if ((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready)) begin
                        axi.bready <= 1'b1;
                        state      <= B;
                    end
                end
                B: begin
                    if (axi.bvalid) begin
                        axi.bready <= 1'b0;
                        if (axi.bresp != 2'b00) err <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_lite_stream_bridge.sv
// Bench for uart_lite_stream_bridge: AXI4-Lite UartLite slave model, byte scoreboards,
// a vector table of single-service scenarios and hand-written multi-cycle sequences.
module tb_uart_lite_stream_bridge;

    localparam int          RX_DEPTH  = 16;
    localparam int          TX_DEPTH  = 16;
    localparam int          DATA_W    = 8;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [4:0]  rx_level;
    logic [4:0]  tx_level;
    logic        err;
    logic        err_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    // Slave configuration, written only by the stimulus process
    int         ar_delay = 1;
    int         aw_delay = 0;
    int         w_delay = 0;
    logic [1:0] bresp_cfg = 2'b00;
    logic [1:0] stat_rresp = 2'b00;
    int         rx_budget = 0;
    logic [7:0] rx_base = 8'h00;
    logic       tx_full_cfg = 1'b0;

    // Slave state
    int          ar_cnt, aw_cnt, w_cnt, rx_served, wr_count, bad_addr;
    logic        aw_got, w_got, wr_done;
    logic [31:0] got_addr, got_data;
    logic [3:0]  got_strb;

    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    int         txn_log[$];

    typedef struct {
        int         budget;
        logic       tx_full;
        logic       push_tx;
        logic [7:0] tx_byte;
        logic [7:0] rx_byte;
        int         exp_first;
        int         exp_rx_level;
        int         exp_tx_level;
        logic [7:0] exp_rx_head;
        logic       exp_rx_valid;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    uart_lite_stream_bridge_if axi();

    uart_lite_stream_bridge #(
        .RX_DEPTH  (RX_DEPTH),
        .TX_DEPTH  (TX_DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .DATA_W    (DATA_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_level (rx_level),
        .tx_level (tx_level),
        .err      (err),
        .err_clr  (err_clr),
        .axi      (axi)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Read side of the peripheral: STAT reports bytes still owed and the forced TX-full bit
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            axi.arready <= 1'b0;
            axi.rvalid  <= 1'b0;
            axi.rdata   <= '0;
            axi.rresp   <= 2'b00;
            ar_cnt      <= 0;
            rx_served   <= 0;
            bad_addr    <= 0;
            rx_exp.delete();
            txn_log.delete();
        end else begin
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
            if (axi.arvalid && axi.arready) begin
                axi.arready <= 1'b0;
                axi.rvalid  <= 1'b1;
                if (axi.araddr == BASE_ADDR + 32'h8) begin
                    axi.rdata <= {28'd0, tx_full_cfg, 2'b00, (rx_served < rx_budget)};
                    axi.rresp <= stat_rresp;
                end else if (axi.araddr == BASE_ADDR) begin
                    axi.rdata <= {24'd0, rx_base + 8'(rx_served)};
                    axi.rresp <= 2'b00;
                    rx_exp.push_back(rx_base + 8'(rx_served));
                    txn_log.push_back(0);
                    rx_served <= rx_served + 1;
                end else begin
                    axi.rdata <= '0;
                    axi.rresp <= 2'b10;
                    bad_addr  <= bad_addr + 1;
                end
            end else if (axi.arvalid && !axi.rvalid) begin
                if (ar_cnt >= ar_delay) begin
                    axi.arready <= 1'b1;
                    ar_cnt      <= 0;
                end else begin
                    ar_cnt <= ar_cnt + 1;
                end
            end
        end
    end

    // Write side: AW and W accepted independently, B issued once both have landed
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            axi.awready <= 1'b0;
            axi.wready  <= 1'b0;
            axi.bvalid  <= 1'b0;
            axi.bresp   <= 2'b00;
            aw_cnt      <= 0;
            w_cnt       <= 0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            wr_done     <= 1'b0;
            wr_count    <= 0;
            got_addr    <= '0;
            got_data    <= '0;
            got_strb    <= '0;
        end else begin
            wr_done <= 1'b0;
            if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
            if (axi.awvalid && axi.awready) begin
                axi.awready <= 1'b0;
                aw_got      <= 1'b1;
                got_addr    <= axi.awaddr;
            end else if (axi.awvalid && !aw_got) begin
                if (aw_cnt >= aw_delay) begin
                    axi.awready <= 1'b1;
                    aw_cnt      <= 0;
                end else begin
                    aw_cnt <= aw_cnt + 1;
                end
            end
            if (axi.wvalid && axi.wready) begin
                axi.wready <= 1'b0;
                w_got      <= 1'b1;
                got_data   <= axi.wdata;
                got_strb   <= axi.wstrb;
            end else if (axi.wvalid && !w_got) begin
                if (w_cnt >= w_delay) begin
                    axi.wready <= 1'b1;
                    w_cnt      <= 0;
                end else begin
                    w_cnt <= w_cnt + 1;
                end
            end
            if (aw_got && w_got) begin
                axi.bvalid <= 1'b1;
                axi.bresp  <= bresp_cfg;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
                wr_done    <= 1'b1;
                wr_count   <= wr_count + 1;
                txn_log.push_back(1);
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && rx_valid && rx_ready) begin
            if (rx_exp.size() == 0) begin
                check_output("rx_pop_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                check_output("rx_pop_data", {24'd0, rx_data}, {24'd0, rx_exp.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && wr_done) begin
            if (tx_exp.size() == 0) begin
                check_output("tx_write_unexpected", got_data, 32'hFFFF_FFFF);
            end else begin
                check_output("tx_write_data", got_data, {24'd0, tx_exp.pop_front()});
            end
            check_output("tx_write_addr", got_addr, BASE_ADDR + 32'h4);
            check_output("tx_write_strb", {28'd0, got_strb}, 32'h1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        tx_valid    = 1'b0;
        rx_ready    = 1'b0;
        err_clr     = 1'b0;
        ar_delay    = 1;
        aw_delay    = 0;
        w_delay     = 0;
        bresp_cfg   = 2'b00;
        stat_rresp  = 2'b00;
        rx_budget   = 0;
        rx_base     = 8'h00;
        tx_full_cfg = 1'b0;
        tx_exp.delete();
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic push_tx(input logic [7:0] b);
        int guard = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && guard < 500) begin
            tick();
            guard++;
        end
        if (!tx_ready) check_output("tx_push_timeout", {31'd0, tx_ready}, 32'h1);
        tx_exp.push_back(b);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        do_reset();
        rx_budget   = v.budget;
        rx_base     = v.rx_byte;
        tx_full_cfg = v.tx_full;
        if (v.push_tx) push_tx(v.tx_byte);
        repeat (80) tick();
    endtask

    initial begin
        vecs[0] = '{1, 1'b0, 1'b0, 8'h00, 8'hA5, 0, 1, 0, 8'hA5, 1'b1};
        vecs[1] = '{0, 1'b0, 1'b1, 8'h3C, 8'h00, 1, 0, 0, 8'h00, 1'b0};
        vecs[2] = '{1, 1'b0, 1'b1, 8'h5A, 8'h11, 0, 1, 0, 8'h11, 1'b1};
        vecs[3] = '{0, 1'b1, 1'b1, 8'h77, 8'h00, 2, 0, 1, 8'h00, 1'b0};
        vecs[4] = '{3, 1'b1, 1'b1, 8'h42, 8'h20, 0, 3, 1, 8'h20, 1'b1};

        // Values held during reset
        repeat (2) tick();
        check_output("rst_arvalid", {31'd0, axi.arvalid}, 32'h0);
        check_output("rst_awvalid", {31'd0, axi.awvalid}, 32'h0);
        check_output("rst_wvalid", {31'd0, axi.wvalid}, 32'h0);
        check_output("rst_rready", {31'd0, axi.rready}, 32'h0);
        check_output("rst_bready", {31'd0, axi.bready}, 32'h0);
        check_output("rst_tx_ready", {31'd0, tx_ready}, 32'h1);
        check_output("rst_rx_valid", {31'd0, rx_valid}, 32'h0);
        check_output("rst_rx_level", {27'd0, rx_level}, 32'h0);
        check_output("rst_tx_level", {27'd0, tx_level}, 32'h0);
        check_output("rst_err", {31'd0, err}, 32'h0);
        check_output("rst_prot", {26'd0, axi.awprot, axi.arprot}, 32'h0);
        check_output("rst_wstrb", {28'd0, axi.wstrb}, 32'h1);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d_first_kind", i),
                         (txn_log.size() > 0) ? txn_log[0] : 2, vecs[i].exp_first);
            check_output($sformatf("vec%0d_rx_level", i), {27'd0, rx_level}, vecs[i].exp_rx_level);
            check_output($sformatf("vec%0d_tx_level", i), {27'd0, tx_level}, vecs[i].exp_tx_level);
            check_output($sformatf("vec%0d_rx_valid", i), {31'd0, rx_valid}, {31'd0, vecs[i].exp_rx_valid});
            if (vecs[i].exp_rx_valid)
                check_output($sformatf("vec%0d_rx_head", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_rx_head});
            rx_ready = 1'b1;
            repeat (20) tick();
            rx_ready = 1'b0;
            check_output($sformatf("vec%0d_rx_drained", i), {27'd0, rx_level}, 32'h0);
        end

        // TX held back while the peripheral reports full, then released in order
        do_reset();
        tx_full_cfg = 1'b1;
        for (int i = 0; i < 4; i++) push_tx(8'h10 + 8'(i));
        repeat (40) tick();
        check_output("bp_no_writes", wr_count, 0);
        check_output("bp_tx_level", {27'd0, tx_level}, 32'h4);
        tx_full_cfg = 1'b0;
        for (int i = 0; i < 500 && tx_level != 0; i++) tick();
        repeat (3) tick();
        check_output("bp_writes", wr_count, 4);
        check_output("bp_tx_empty", {27'd0, tx_level}, 32'h0);

        // RX and TX both pending on every poll: service must alternate, RX first
        do_reset();
        rx_budget = 1000;
        rx_base   = 8'h80;
        rx_ready  = 1'b1;
        for (int i = 0; i < 4; i++) push_tx(8'hC0 + 8'(i));
        for (int i = 0; i < 1000 && wr_count < 4; i++) tick();
        check_output("fair_writes", wr_count, 4);
        for (int i = 0; i < 8; i++)
            check_output($sformatf("fair_order%0d", i),
                         (txn_log.size() > i) ? txn_log[i] : 9, i % 2);

        // RX buffer fills with no consumer, then reads stop at the depth
        do_reset();
        rx_budget = 100;
        rx_base   = 8'h40;
        repeat (300) tick();
        check_output("full_rx_level", {27'd0, rx_level}, RX_DEPTH);
        check_output("full_rx_reads", rx_served, RX_DEPTH);
        check_output("full_rx_valid", {31'd0, rx_valid}, 32'h1);
        rx_budget = RX_DEPTH;
        rx_ready  = 1'b1;
        repeat (40) tick();
        rx_ready = 1'b0;
        check_output("full_drained", {27'd0, rx_level}, 32'h0);
        check_output("full_sb_empty", rx_exp.size(), 0);

        // Write error response: byte consumed, err sticky until cleared
        do_reset();
        bresp_cfg = 2'b10;
        push_tx(8'hE1);
        for (int i = 0; i < 200 && wr_count < 1; i++) tick();
        repeat (4) tick();
        check_output("berr_set", {31'd0, err}, 32'h1);
        check_output("berr_tx_popped", {27'd0, tx_level}, 32'h0);
        repeat (10) tick();
        check_output("berr_sticky", {31'd0, err}, 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_output("berr_cleared", {31'd0, err}, 32'h0);

        // Error response landing while err_clr is held: the set wins
        err_clr = 1'b1;
        push_tx(8'hE2);
        for (int i = 0; i < 200 && !(axi.bvalid && axi.bready); i++) tick();
        check_output("setwin_before", {31'd0, err}, 32'h0);
        tick();
        check_output("setwin_err", {31'd0, err}, 32'h1);
        err_clr = 1'b0;
        tick();
        check_output("setwin_sticky", {31'd0, err}, 32'h1);

        // STAT read error suppresses service for that poll
        do_reset();
        stat_rresp = 2'b10;
        rx_budget  = 1;
        rx_base    = 8'h5E;
        repeat (40) tick();
        check_output("staterr_no_read", rx_served, 0);
        check_output("staterr_err", {31'd0, err}, 32'h1);
        stat_rresp = 2'b00;
        for (int i = 0; i < 200 && rx_level == 0; i++) tick();
        check_output("staterr_recover", {27'd0, rx_level}, 32'h1);
        check_output("staterr_head", {24'd0, rx_data}, 32'h5E);

        // awready much later than wready still yields exactly one write
        do_reset();
        aw_delay = 5;
        w_delay  = 1;
        push_tx(8'h99);
        for (int i = 0; i < 200 && wr_count < 1; i++) tick();
        repeat (20) tick();
        check_output("skew_writes", wr_count, 1);
        check_output("skew_tx_level", {27'd0, tx_level}, 32'h0);
        check_output("skew_err", {31'd0, err}, 32'h0);
        check_output("bad_addr", bad_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
